// File: rtl/apb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_ram_arbiter
// Purpose  : Round-robin APB master sharing one apb_ram slave between two
//            command sources, with pready timeout abort.
// Revision : 1.0
// ============================================================================
module apb_ram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid_0,
  output logic              cmd_ready_0,
  input  logic              cmd_write_0,
  input  logic [ADDR_W-1:0] cmd_addr_0,
  input  logic [DATA_W-1:0] cmd_wdata_0,
  input  logic              cmd_valid_1,
  output logic              cmd_ready_1,
  input  logic              cmd_write_1,
  input  logic [ADDR_W-1:0] cmd_addr_1,
  input  logic [DATA_W-1:0] cmd_wdata_1,
  output logic              rsp_valid_0,
  output logic [DATA_W-1:0] rsp_rdata_0,
  output logic              rsp_err_0,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_rdata_1,
  output logic              rsp_err_1,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // Counter holds 0..TIMEOUT-1; the abort fires on the last low-pready cycle.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SETUP  = 2'd1;
  localparam logic [1:0] c_ACCESS = 2'd2;

  logic [1:0]       r_state;
  logic             r_owner;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt;

  logic              w_grant_0;
  logic              w_grant_1;
  logic              w_idle;
  logic              w_done;
  logic [DATA_W-1:0] w_rsp_rdata;
  logic              w_rsp_err;

  // On contention the requester that did not win last time gets the bus.
  assign w_grant_0 = cmd_valid_0 && (!cmd_valid_1 ||  r_last_grant);
  assign w_grant_1 = cmd_valid_1 && (!cmd_valid_0 || !r_last_grant);
  assign w_idle    = (r_state == c_IDLE);

  assign cmd_ready_0 = w_idle && w_grant_0;
  assign cmd_ready_1 = w_idle && w_grant_1;

  assign w_done      = (r_state == c_ACCESS) && (pready || (r_cnt == c_CNT_LAST));
  assign w_rsp_rdata = pready ? prdata  : '0;
  assign w_rsp_err   = pready ? pslverr : 1'b1;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state      <= c_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_grant_0 || w_grant_1) begin
            pwrite       <= w_grant_1 ? cmd_write_1 : cmd_write_0;
            paddr        <= w_grant_1 ? cmd_addr_1  : cmd_addr_0;
            pwdata       <= w_grant_1 ? cmd_wdata_1 : cmd_wdata_0;
            r_owner      <= w_grant_1;
            r_last_grant <= w_grant_1;
            psel         <= 1'b1;
            penable      <= 1'b0;
            r_state      <= c_SETUP;
          end
        end
        c_SETUP: begin
          penable <= 1'b1;
          r_cnt   <= '0;
          r_state <= c_ACCESS;
        end
        c_ACCESS: begin
          if (w_done) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            r_state <= c_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Response registers: only the owner's side is ever updated.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rsp_valid_0 <= 1'b0;
      rsp_rdata_0 <= '0;
      rsp_err_0   <= 1'b0;
      rsp_valid_1 <= 1'b0;
      rsp_rdata_1 <= '0;
      rsp_err_1   <= 1'b0;
    end else begin
      rsp_valid_0 <= w_done && !r_owner;
      rsp_valid_1 <= w_done &&  r_owner;
      if (w_done && !r_owner) begin
        rsp_rdata_0 <= w_rsp_rdata;
        rsp_err_0   <= w_rsp_err;
      end
      if (w_done && r_owner) begin
        rsp_rdata_1 <= w_rsp_rdata;
        rsp_err_1   <= w_rsp_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_ram_arbiter
// Purpose  : Directed + randomized bench for apb_ram_arbiter with an APB RAM
//            slave and a transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_apb_ram_arbiter;

  localparam int TIMEOUT = 16;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        cmd_valid_0 = 1'b0, cmd_valid_1 = 1'b0;
  logic        cmd_ready_0, cmd_ready_1;
  logic        cmd_write_0 = 1'b0, cmd_write_1 = 1'b0;
  logic [31:0] cmd_addr_0 = '0, cmd_addr_1 = '0;
  logic [31:0] cmd_wdata_0 = '0, cmd_wdata_1 = '0;
  logic        rsp_valid_0, rsp_valid_1, rsp_err_0, rsp_err_1;
  logic [31:0] rsp_rdata_0, rsp_rdata_1;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0, pslverr = 1'b0;

  apb_ram_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid_0(cmd_valid_0), .cmd_ready_0(cmd_ready_0), .cmd_write_0(cmd_write_0),
    .cmd_addr_0(cmd_addr_0), .cmd_wdata_0(cmd_wdata_0),
    .cmd_valid_1(cmd_valid_1), .cmd_ready_1(cmd_ready_1), .cmd_write_1(cmd_write_1),
    .cmd_addr_1(cmd_addr_1), .cmd_wdata_1(cmd_wdata_1),
    .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0), .rsp_err_0(rsp_err_0),
    .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1), .rsp_err_1(rsp_err_1),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit          owner;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  int          checks = 0, errors = 0, cyc = 0;
  cmd_t        q0[$], q1[$], exp_q[$];
  bit          m_last = 1'b1;
  logic [31:0] ref_mem [64];
  logic [31:0] slv_mem [64];
  bit          pend = 1'b0;
  cmd_t        pend_cmd;
  int          pend_due = 0;
  bit          pend_err = 1'b0;
  logic [31:0] pend_rdata = '0;
  bit          hs_pending = 1'b0, hs_req = 1'b0;
  int          setup_due = -100;
  bit          prev_psel = 1'b0;
  int          acc_cnt = 0;
  int          wait_sel = 0, err_sel = 0;
  bit          hang = 1'b0;
  logic [31:0] last_rd [2];
  bit          last_er [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave behaviour knobs: fixed values, or derived from the address when -1.
  function automatic int wait_of(input logic [31:0] a);
    return (wait_sel >= 0) ? wait_sel : int'(a[3:2]);
  endfunction

  function automatic bit err_of(input logic [31:0] a);
    return (err_sel >= 0) ? err_sel[0] : (a[7:4] == 4'hA);
  endfunction

  task automatic add(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    cmd_t c;
    c.owner = r; c.write = w; c.addr = a; c.wdata = d;
    if (r) q1.push_back(c); else q0.push_back(c);
  endtask

  // Both requesters hold valid until drained: alternate while both have work.
  task automatic plan();
    cmd_t a[$];
    cmd_t b[$];
    bit   pick;
    a = q0; b = q1;
    while (a.size() > 0 || b.size() > 0) begin
      if (a.size() > 0 && b.size() > 0) pick = !m_last;
      else pick = (b.size() > 0);
      if (pick) begin exp_q.push_back(b[0]); b.delete(0); end
      else begin exp_q.push_back(a[0]); a.delete(0); end
      m_last = pick;
    end
  endtask

  task automatic drive();
    cmd_valid_0 = (q0.size() > 0);
    cmd_valid_1 = (q1.size() > 0);
    if (cmd_valid_0) begin
      cmd_write_0 = q0[0].write; cmd_addr_0 = q0[0].addr; cmd_wdata_0 = q0[0].wdata;
    end else begin
      cmd_write_0 = 1'($urandom); cmd_addr_0 = $urandom; cmd_wdata_0 = $urandom;
    end
    if (cmd_valid_1) begin
      cmd_write_1 = q1[0].write; cmd_addr_1 = q1[0].addr; cmd_wdata_1 = q1[0].wdata;
    end else begin
      cmd_write_1 = 1'($urandom); cmd_addr_1 = $urandom; cmd_wdata_1 = $urandom;
    end
  endtask

  task automatic monitor();
    cmd_t e;
    bit   r;
    int   idx;
    if (cmd_ready_0 || cmd_ready_1) begin
      chk("single_ready", {31'd0, cmd_ready_0 & cmd_ready_1}, 0);
      r = cmd_ready_1;
      chk("ready_needs_valid", r ? cmd_valid_1 : cmd_valid_0, 1);
      if (exp_q.size() == 0) chk("unexpected_grant", {cmd_ready_1, cmd_ready_0}, 0);
      else chk("grant_owner", r, exp_q[0].owner);
      hs_pending = 1'b1; hs_req = r; setup_due = cyc + 1;
    end
    if (psel && !penable) begin
      chk("psel_gap", prev_psel, 0);
      chk("setup_timing", cyc, setup_due);
      if (exp_q.size() > 0) begin
        e = exp_q[0]; exp_q.delete(0);
        idx = int'(e.addr[7:2]);
        chk("setup_paddr", paddr, e.addr);
        chk("setup_pwrite", pwrite, e.write);
        chk("setup_pwdata", pwdata, e.wdata);
        pend = 1'b1; pend_cmd = e;
        if (hang) begin
          pend_due = cyc + TIMEOUT + 1; pend_err = 1'b1; pend_rdata = '0;
        end else begin
          pend_due = cyc + wait_of(e.addr) + 2; pend_err = err_of(e.addr);
          pend_rdata = ref_mem[idx];
          if (e.write && !pend_err) ref_mem[idx] = e.wdata;
        end
      end
    end
    if (psel && penable && pend) begin
      chk("access_paddr", paddr, pend_cmd.addr);
      chk("access_pwrite", pwrite, pend_cmd.write);
    end
    if (rsp_valid_0 || rsp_valid_1) begin
      if (!pend) chk("spurious_rsp", {rsp_valid_1, rsp_valid_0}, 0);
      else begin
        r = pend_cmd.owner;
        chk("rsp_valid_pair", {rsp_valid_1, rsp_valid_0}, r ? 2'b10 : 2'b01);
        chk("rsp_time", cyc, pend_due);
        chk("rsp_rdata", r ? rsp_rdata_1 : rsp_rdata_0, pend_rdata);
        chk("rsp_err", r ? rsp_err_1 : rsp_err_0, pend_err);
        chk("psel_after_rsp", psel, 0);
        chk("nonowner_hold", r ? {rsp_err_0, rsp_rdata_0} : {rsp_err_1, rsp_rdata_1},
            {last_er[!r], last_rd[!r]});
        last_rd[r] = pend_rdata; last_er[r] = pend_err; pend = 1'b0;
      end
    end else begin
      if (pend && cyc >= pend_due) begin
        chk("rsp_missing", {rsp_valid_1, rsp_valid_0}, pend_cmd.owner ? 2'b10 : 2'b01);
        pend = 1'b0;
      end
      chk("hold0", {rsp_err_0, rsp_rdata_0}, {last_er[0], last_rd[0]});
      chk("hold1", {rsp_err_1, rsp_rdata_1}, {last_er[1], last_rd[1]});
    end
    prev_psel = psel;
  endtask

  task automatic slave();
    if (psel && penable) begin
      if (!hang && acc_cnt >= wait_of(paddr)) begin
        pready = 1'b1; pslverr = err_of(paddr); prdata = slv_mem[paddr[7:2]];
        if (pwrite && !pslverr) slv_mem[paddr[7:2]] = pwdata;
        acc_cnt = 0;
      end else begin
        pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom; acc_cnt++;
      end
    end else begin
      acc_cnt = 0; pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
    end
  endtask

  task automatic cycle();
    @(posedge pclk); #1;
    if (hs_pending) begin
      if (hs_req) q1.delete(0); else q0.delete(0);
      hs_pending = 1'b0;
    end
    drive();
    @(negedge pclk);
    cyc++;
    monitor();
    slave();
  endtask

  task automatic run(input int budget);
    int n = 0;
    plan();
    while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0 || pend || hs_pending) && n < budget) begin
      cycle(); n++;
    end
    chk("run_complete", q0.size() + q1.size() + exp_q.size() + int'(pend), 0);
    cycle(); cycle();
  endtask

  initial begin
    int n;
    logic [31:0] v;
    for (int i = 0; i < 64; i++) begin
      v = $urandom; ref_mem[i] = v; slv_mem[i] = v;
    end
    last_rd[0] = '0; last_rd[1] = '0; last_er[0] = 1'b0; last_er[1] = 1'b0;

    // Reset values
    repeat (2) @(negedge pclk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp", {rsp_valid_1, rsp_err_1, rsp_valid_0, rsp_err_0}, 0);
    chk("rst_rdata", {rsp_rdata_1, rsp_rdata_0}, 0);
    chk("rst_ready", {cmd_ready_1, cmd_ready_0}, 0);
    presetn = 1'b1;

    // Zero-wait write then read-back from the other requester
    wait_sel = 0; err_sel = 0;
    add(0, 1, 32'h04, 32'hDEADBEEF);
    run(30);
    add(1, 0, 32'h04, 32'h0);
    run(30);
    chk("readback_deadbeef", rsp_rdata_1, 32'hDEADBEEF);
    chk("readback_err", rsp_err_1, 0);

    // Contention: four commands each
    for (int i = 0; i < 4; i++) begin
      add(0, 1, 32'(i * 4), $urandom);
      add(1, 0, 32'(i * 4), $urandom);
    end
    run(100);

    // Three wait states on a read
    wait_sel = 3;
    add(0, 0, 32'h08, 32'h0);
    run(30);
    wait_sel = 0;

    // Timeout abort, then a normal transfer
    hang = 1'b1;
    add(1, 0, 32'h0C, 32'h0);
    run(60);
    chk("timeout_err", rsp_err_1, 1);
    chk("timeout_rdata", rsp_rdata_1, 0);
    hang = 1'b0;
    add(1, 0, 32'h0C, 32'h0);
    run(30);
    chk("after_timeout_err", rsp_err_1, 0);

    // Slave error
    err_sel = 1;
    add(0, 0, 32'h10, 32'h0);
    run(30);
    chk("pslverr_err", rsp_err_0, 1);

    // Randomized traffic with address-derived waits/errors
    wait_sel = -1; err_sel = -1;
    for (int round = 0; round < 8; round++) begin
      for (int k = $urandom_range(0, 5); k > 0; k--) add(0, 1'($urandom), $urandom & 32'hFC, $urandom);
      for (int k = $urandom_range(0, 5); k > 0; k--) add(1, 1'($urandom), $urandom & 32'hFC, $urandom);
      run(400);
    end

    // Reset during ACCESS abandons the transfer
    wait_sel = 0; err_sel = 0; hang = 1'b1;
    add(0, 0, 32'h40, 32'h0);
    plan();
    n = 0;
    while (!(psel && penable) && n < 10) begin cycle(); n++; end
    chk("reached_access", {31'd0, psel & penable}, 1);
    presetn = 1'b0;
    #1;
    chk("mid_rst_psel", psel, 0);
    chk("mid_rst_penable", penable, 0);
    chk("mid_rst_rsp_valid", {rsp_valid_1, rsp_valid_0}, 0);
    hang = 1'b0; pend = 1'b0; hs_pending = 1'b0; m_last = 1'b1; acc_cnt = 0;
    exp_q.delete(); q0.delete(); q1.delete();
    last_rd[0] = '0; last_rd[1] = '0; last_er[0] = 1'b0; last_er[1] = 1'b0;
    cmd_valid_0 = 1'b0; cmd_valid_1 = 1'b0; pready = 1'b0;
    prev_psel = 1'b0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    add(0, 1, 32'h20, 32'h12345678);
    add(1, 1, 32'h24, 32'h9ABCDEF0);
    run(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
